// File: rtl/vx_cache_core_req_dispatch.sv
// Registers one core request batch and drains it into the per-bank request queues,
// issuing at most one lane per bank per cycle in ascending lane order.
module vx_cache_core_req_dispatch #(
    parameter int unsigned BANK_LINE_SIZE  = 16,
    parameter int unsigned WORD_SIZE       = 4,
    parameter int unsigned NUM_BANKS       = 4,
    parameter int unsigned NUM_REQUESTS    = 4,
    parameter int unsigned WORD_ADDR_WIDTH = 30,
    parameter int unsigned TAG_WIDTH       = 8,
    localparam int unsigned IDX_W = (NUM_REQUESTS > 1) ? $clog2(NUM_REQUESTS) : 1
) (
    input  logic                                 clk,
    input  logic                                 reset,
    input  logic [NUM_REQUESTS-1:0]              core_req_valid,
    input  logic [NUM_REQUESTS*WORD_ADDR_WIDTH-1:0] core_req_addr,
    input  logic [TAG_WIDTH-1:0]                 core_req_tag,
    input  logic                                 split_en,
    output logic                                 core_req_ready,
    output logic [NUM_BANKS-1:0]                 per_bank_valid,
    output logic [NUM_BANKS*WORD_ADDR_WIDTH-1:0] per_bank_addr,
    output logic [NUM_BANKS*IDX_W-1:0]           per_bank_req_idx,
    output logic [NUM_BANKS*TAG_WIDTH-1:0]       per_bank_tag,
    input  logic [NUM_BANKS-1:0]                 per_bank_ready,
    output logic                                 busy,
    output logic [31:0]                          perf_conflict_stalls
);

    localparam int unsigned OFS    = $clog2(BANK_LINE_SIZE / WORD_SIZE);
    localparam int unsigned BANK_W = (NUM_BANKS > 1) ? $clog2(NUM_BANKS) : 1;

    if (NUM_BANKS < NUM_REQUESTS) begin : g_cfg_err
        $error("split mode needs NUM_BANKS >= NUM_REQUESTS");
    end

    typedef enum logic {StIdle, StDispatch} state_e;

    state_e                     state_q, state_d;
    logic [NUM_REQUESTS-1:0]    pending_q, pending_d;
    logic [WORD_ADDR_WIDTH-1:0] addr_q [NUM_REQUESTS];
    logic [TAG_WIDTH-1:0]       tag_q;
    logic                       split_q;
    logic [31:0]                stalls_q, stalls_d;

    logic [BANK_W-1:0]       lane_bank [NUM_REQUESTS];
    logic [NUM_REQUESTS-1:0] granted, taken;
    logic                    drain, conflict, accept;

    // A lane is granted when no lower pending lane targets the same bank.
    always_comb begin
        granted = '0;
        taken   = '0;
        for (int i = 0; i < NUM_REQUESTS; i++) begin
            if (NUM_BANKS == 1)  lane_bank[i] = '0;
            else if (split_q)    lane_bank[i] = BANK_W'(i);
            else                 lane_bank[i] = addr_q[i][OFS +: BANK_W];
        end
        for (int i = 0; i < NUM_REQUESTS; i++) begin
            granted[i] = pending_q[i];
            for (int j = 0; j < i; j++) begin
                if (pending_q[j] && (lane_bank[j] == lane_bank[i])) granted[i] = 1'b0;
            end
            taken[i] = granted[i] && per_bank_ready[lane_bank[i]];
        end
    end

    always_comb begin
        per_bank_valid   = '0;
        per_bank_addr    = '0;
        per_bank_req_idx = '0;
        per_bank_tag     = '0;
        for (int b = 0; b < NUM_BANKS; b++) begin
            for (int i = 0; i < NUM_REQUESTS; i++) begin
                if (granted[i] && (lane_bank[i] == BANK_W'(b))) begin
                    per_bank_valid[b]                               = 1'b1;
                    per_bank_addr[b*WORD_ADDR_WIDTH +: WORD_ADDR_WIDTH] = addr_q[i];
                    per_bank_req_idx[b*IDX_W +: IDX_W]              = IDX_W'(i);
                    per_bank_tag[b*TAG_WIDTH +: TAG_WIDTH]          = tag_q;
                end
            end
        end
    end

    always_comb begin
        drain          = ((pending_q & ~taken) == '0);
        conflict       = |(pending_q & ~granted);
        core_req_ready = (state_q == StIdle) || drain;
        accept         = (|core_req_valid) && core_req_ready;
        busy           = |pending_q;

        state_d   = state_q;
        pending_d = pending_q & ~taken;
        stalls_d  = stalls_q;
        case (state_q)
            StIdle: begin
                if (accept) begin
                    state_d   = StDispatch;
                    pending_d = core_req_valid;
                end
            end
            StDispatch: begin
                if (conflict && (stalls_q != '1)) stalls_d = stalls_q + 32'd1;
                if (accept)     pending_d = core_req_valid;
                else if (drain) state_d   = StIdle;
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= StIdle;
            pending_q <= '0;
            stalls_q  <= '0;
            split_q   <= 1'b0;
            tag_q     <= '0;
            for (int i = 0; i < NUM_REQUESTS; i++) addr_q[i] <= '0;
        end else begin
            state_q   <= state_d;
            pending_q <= pending_d;
            stalls_q  <= stalls_d;
            if (accept) begin
                split_q <= split_en;
                tag_q   <= core_req_tag;
                for (int i = 0; i < NUM_REQUESTS; i++) begin
                    addr_q[i] <= core_req_addr[i*WORD_ADDR_WIDTH +: WORD_ADDR_WIDTH];
                end
            end
        end
    end

    assign perf_conflict_stalls = stalls_q;

`ifndef SYNTHESIS
    always_ff @(posedge clk) begin
        if (!reset) begin
            for (int b = 0; b < NUM_BANKS; b++) begin
                if (per_bank_valid[b]) begin
                    assert (pending_q[per_bank_req_idx[b*IDX_W +: IDX_W]])
                        else $error("bank %0d valid for a lane that is not pending", b);
                    for (int c = b + 1; c < NUM_BANKS; c++) begin
                        assert (!per_bank_valid[c] ||
                                per_bank_req_idx[b*IDX_W +: IDX_W] !=
                                per_bank_req_idx[c*IDX_W +: IDX_W])
                            else $error("lane granted to banks %0d and %0d", b, c);
                    end
                end
            end
        end
    end
`endif

endmodule

// File: tb/tb_vx_cache_core_req_dispatch.sv
// Scoreboarded bench: expected bank issues are queued at batch accept and retired as banks take them.
module tb_vx_cache_core_req_dispatch;

    localparam int NB = 4;
    localparam int NR = 4;
    localparam int AW = 30;
    localparam int TW = 8;
    localparam int IW = 2;

    logic             clk = 1'b0;
    logic             reset;
    logic [NR-1:0]    core_req_valid;
    logic [NR*AW-1:0] core_req_addr;
    logic [TW-1:0]    core_req_tag;
    logic             split_en;
    logic             core_req_ready;
    logic [NB-1:0]    per_bank_valid;
    logic [NB*AW-1:0] per_bank_addr;
    logic [NB*IW-1:0] per_bank_req_idx;
    logic [NB*TW-1:0] per_bank_tag;
    logic [NB-1:0]    per_bank_ready;
    logic             busy;
    logic [31:0]      perf_conflict_stalls;

    vx_cache_core_req_dispatch dut (
        .clk                  (clk),
        .reset                (reset),
        .core_req_valid       (core_req_valid),
        .core_req_addr        (core_req_addr),
        .core_req_tag         (core_req_tag),
        .split_en             (split_en),
        .core_req_ready       (core_req_ready),
        .per_bank_valid       (per_bank_valid),
        .per_bank_addr        (per_bank_addr),
        .per_bank_req_idx     (per_bank_req_idx),
        .per_bank_tag         (per_bank_tag),
        .per_bank_ready       (per_bank_ready),
        .busy                 (busy),
        .perf_conflict_stalls (perf_conflict_stalls)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [1:0]    bank;
        logic [IW-1:0] idx;
        logic [AW-1:0] addr;
        logic [TW-1:0] tag;
    } exp_t;

    exp_t sb[$];
    int   n_checks = 0;
    int   n_errors = 0;
    int   exp_stalls = 0;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [AW-1:0] mk_addr(input int bank, input int hi);
        logic [AW-1:0] a;
        a = {26'(hi), 2'(bank), 2'b01};
        return a;
    endfunction

    task automatic set_lane(input int lane, input int bank, input int hi);
        core_req_addr[lane*AW +: AW] = mk_addr(bank, hi);
    endtask

    // Retire issues before queueing a newly accepted batch so older lanes stay ahead.
    int   pos;
    exp_t e;
    always @(negedge clk) begin
        if (reset) begin
            sb.delete();
        end else begin
            for (int b = 0; b < NB; b++) begin
                if (per_bank_valid[b] && per_bank_ready[b]) begin
                    pos = -1;
                    for (int k = 0; k < sb.size(); k++) begin
                        if (pos < 0 && sb[k].bank == 2'(b)) pos = k;
                    end
                    if (pos < 0) begin
                        check_eq("sb_unexpected_issue", 32'(b), 32'hFFFF_FFFF);
                    end else begin
                        check_eq("sb_idx",  32'(per_bank_req_idx[b*IW +: IW]), 32'(sb[pos].idx));
                        check_eq("sb_addr", 32'(per_bank_addr[b*AW +: AW]),   32'(sb[pos].addr));
                        check_eq("sb_tag",  32'(per_bank_tag[b*TW +: TW]),    32'(sb[pos].tag));
                        sb.delete(pos);
                    end
                end
            end
            if ((|core_req_valid) && core_req_ready) begin
                for (int i = 0; i < NR; i++) begin
                    if (core_req_valid[i]) begin
                        e.idx  = IW'(i);
                        e.addr = core_req_addr[i*AW +: AW];
                        e.tag  = core_req_tag;
                        e.bank = split_en ? 2'(i) : e.addr[3:2];
                        sb.push_back(e);
                    end
                end
            end
        end
    end

    initial begin
        reset          = 1'b1;
        core_req_valid = '0;
        core_req_addr  = '0;
        core_req_tag   = '0;
        split_en       = 1'b0;
        per_bank_ready = '1;
        tick();
        tick();
        check_eq("rst_valid", 32'(per_bank_valid), 32'h0);
        check_eq("rst_busy", 32'(busy), 32'h0);
        check_eq("rst_ready", 32'(core_req_ready), 32'h1);
        check_eq("rst_stalls", perf_conflict_stalls, 32'h0);
        reset = 1'b0;

        // 1: no conflict
        for (int i = 0; i < NR; i++) set_lane(i, i, 16 + i);
        core_req_tag   = 8'hA1;
        core_req_valid = 4'b1111;
        #1 check_eq("s1_ready_idle", 32'(core_req_ready), 32'h1);
        tick();
        core_req_valid = '0;
        #1;
        check_eq("s1_valid", 32'(per_bank_valid), 32'hF);
        check_eq("s1_busy", 32'(busy), 32'h1);
        check_eq("s1_ready_drain", 32'(core_req_ready), 32'h1);
        tick();
        check_eq("s1_busy_after", 32'(busy), 32'h0);
        check_eq("s1_valid_after", 32'(per_bank_valid), 32'h0);
        check_eq("s1_stalls", perf_conflict_stalls, 32'(exp_stalls));

        // 2: full conflict on bank 2
        for (int i = 0; i < NR; i++) set_lane(i, 2, 40 + i);
        core_req_tag   = 8'hB2;
        core_req_valid = 4'b1111;
        tick();
        core_req_valid = '0;
        #1;
        for (int k = 0; k < 4; k++) begin
            check_eq("s2_valid", 32'(per_bank_valid), 32'h4);
            check_eq("s2_idx", 32'(per_bank_req_idx[2*IW +: IW]), 32'(k));
            check_eq("s2_ready", 32'(core_req_ready), 32'(k == 3));
            if (k < 3) exp_stalls++;
            tick();
        end
        check_eq("s2_stalls", perf_conflict_stalls, 32'(exp_stalls));
        check_eq("s2_busy_after", 32'(busy), 32'h0);

        // 3: bank 1 backpressure for 3 cycles
        for (int i = 0; i < NR; i++) set_lane(i, i, 60 + i);
        core_req_tag   = 8'hC3;
        per_bank_ready = 4'b1101;
        core_req_valid = 4'b1111;
        tick();
        core_req_valid = '0;
        #1;
        check_eq("s3_valid_first", 32'(per_bank_valid), 32'hF);
        for (int k = 0; k < 3; k++) begin
            if (k > 0) check_eq("s3_valid_hold", 32'(per_bank_valid), 32'h2);
            check_eq("s3_idx1", 32'(per_bank_req_idx[1*IW +: IW]), 32'h1);
            check_eq("s3_addr1", 32'(per_bank_addr[1*AW +: AW]), 32'(mk_addr(1, 61)));
            check_eq("s3_ready_blocked", 32'(core_req_ready), 32'h0);
            tick();
        end
        per_bank_ready = '1;
        #1;
        check_eq("s3_valid_release", 32'(per_bank_valid), 32'h2);
        check_eq("s3_ready_release", 32'(core_req_ready), 32'h1);
        tick();
        check_eq("s3_busy_after", 32'(busy), 32'h0);
        check_eq("s3_stalls", perf_conflict_stalls, 32'(exp_stalls));

        // 4: split mode, sparse batch, every address decodes to bank 0
        for (int i = 0; i < NR; i++) set_lane(i, 0, 80 + i);
        core_req_tag   = 8'hD4;
        split_en       = 1'b1;
        core_req_valid = 4'b0101;
        tick();
        core_req_valid = '0;
        split_en       = 1'b0;
        #1;
        check_eq("s4_valid", 32'(per_bank_valid), 32'h5);
        check_eq("s4_idx0", 32'(per_bank_req_idx[0*IW +: IW]), 32'h0);
        check_eq("s4_idx2", 32'(per_bank_req_idx[2*IW +: IW]), 32'h2);
        tick();
        check_eq("s4_busy_after", 32'(busy), 32'h0);

        // 5: back-to-back batches
        for (int i = 0; i < NR; i++) set_lane(i, 3 - i, 100 + i);
        core_req_tag   = 8'h11;
        core_req_valid = 4'b1111;
        tick();
        for (int i = 0; i < NR; i++) set_lane(i, i, 120 + i);
        core_req_tag = 8'h22;
        #1;
        check_eq("s5_tag_a", 32'(per_bank_tag[0 +: TW]), 32'h11);
        check_eq("s5_ready_overlap", 32'(core_req_ready), 32'h1);
        tick();
        core_req_valid = '0;
        #1;
        check_eq("s5_valid_b", 32'(per_bank_valid), 32'hF);
        check_eq("s5_tag_b", 32'(per_bank_tag[3*TW +: TW]), 32'h22);
        tick();
        check_eq("s5_busy_after", 32'(busy), 32'h0);
        check_eq("s5_stalls", perf_conflict_stalls, 32'(exp_stalls));

        // 6: reset during the second dispatch cycle of a full conflict
        for (int i = 0; i < NR; i++) set_lane(i, 2, 140 + i);
        core_req_tag   = 8'hE6;
        core_req_valid = 4'b1111;
        tick();
        core_req_valid = '0;
        tick();
        reset = 1'b1;
        tick();
        reset = 1'b0;
        exp_stalls = 0;
        #1;
        check_eq("s6_valid", 32'(per_bank_valid), 32'h0);
        check_eq("s6_busy", 32'(busy), 32'h0);
        check_eq("s6_ready", 32'(core_req_ready), 32'h1);
        check_eq("s6_stalls", perf_conflict_stalls, 32'h0);
        set_lane(3, 1, 160);
        core_req_tag   = 8'hF7;
        core_req_valid = 4'b1000;
        tick();
        core_req_valid = '0;
        #1;
        check_eq("s6_new_valid", 32'(per_bank_valid), 32'h2);
        check_eq("s6_new_idx", 32'(per_bank_req_idx[1*IW +: IW]), 32'h3);
        tick();
        check_eq("s6_new_busy_after", 32'(busy), 32'h0);

        tick();
        check_eq("sb_drained", 32'(sb.size()), 32'h0);
        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
